// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the MAC datapath floating-point units.
package fp_pkg;

  localparam logic signed [9:0] BIAS    = 10'sd127;
  localparam logic signed [9:0] EXP_MAX = 10'sd255;
  localparam logic [31:0]       QNAN    = 32'h7FC00000;
  localparam logic [31:0]       POS_INF = 32'h7F800000;

  typedef enum logic [1:0] {IDLE, UNPACK, DIVIDE, NORM} div_state_e;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_e;

endpackage

// File: rtl/fp_classify.sv
// Splits a binary32 value into its fields and classifies it; denormals count as zero.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] i_val,
  output fp_class_e   o_class,
  output logic        o_sign,
  output logic [7:0]  o_exp,
  output logic [22:0] o_mant
);

  always_comb begin
    o_sign  = i_val[31];
    o_exp   = i_val[30:23];
    o_mant  = i_val[22:0];
    o_class = NORMAL;
    if (i_val[30:23] == 8'd0) begin
      o_class = ZERO;
    end else if (i_val[30:23] == 8'hFF) begin
      o_class = (i_val[22:0] == 23'd0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential binary32 divider: radix-2 restoring mantissa division, truncating result,
// start/busy/done handshake.
module fp_div_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  div_state_e         r_state;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_sign;
  logic               r_special;
  logic [31:0]        r_specRes;
  logic [24:0]        r_rem;
  logic [23:0]        r_mb;
  logic [24:0]        r_q;
  logic signed [9:0]  r_exp;
  logic [4:0]         r_count;
  logic [31:0]        r_result;
  logic               r_busy;
  logic               r_done;

  fp_class_e          w_aClass;
  fp_class_e          w_bClass;
  logic               w_aSign;
  logic               w_bSign;
  logic [7:0]         w_aExp;
  logic [7:0]         w_bExp;
  logic [22:0]        w_aMant;
  logic [22:0]        w_bMant;
  logic               w_sign;
  logic               w_isSpecial;
  logic [31:0]        w_specRes;
  logic               w_ge;
  logic [24:0]        w_sub;
  logic [24:0]        w_remNext;
  logic signed [9:0]  w_normExp;
  logic [22:0]        w_normMant;
  logic [31:0]        w_normResult;

  fp_classify u_classA (
    .i_val   (r_a),
    .o_class (w_aClass),
    .o_sign  (w_aSign),
    .o_exp   (w_aExp),
    .o_mant  (w_aMant)
  );

  fp_classify u_classB (
    .i_val   (r_b),
    .o_class (w_bClass),
    .o_sign  (w_bSign),
    .o_exp   (w_bExp),
    .o_mant  (w_bMant)
  );

  // NaN-producing cases outrank infinities, which outrank zeros.
  always_comb begin
    w_sign      = w_aSign ^ w_bSign;
    w_isSpecial = 1'b1;
    w_specRes   = 32'h0;
    if (w_aClass == NAN || w_bClass == NAN ||
        (w_aClass == ZERO && w_bClass == ZERO) ||
        (w_aClass == INF && w_bClass == INF)) begin
      w_specRes = QNAN;
    end else if (w_bClass == ZERO || w_aClass == INF) begin
      w_specRes = {w_sign, POS_INF[30:0]};
    end else if (w_aClass == ZERO || w_bClass == INF) begin
      w_specRes = {w_sign, 31'h0};
    end else begin
      w_isSpecial = 1'b0;
    end
  end

  always_comb begin
    w_ge      = (r_rem >= {1'b0, r_mb});
    w_sub     = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
    w_remNext = {w_sub[23:0], 1'b0};
  end

  // A quotient below 1.0 needs one extra left shift, paid for in the exponent.
  always_comb begin
    w_normExp    = r_q[24] ? r_exp : (r_exp - 10'sd1);
    w_normMant   = r_q[24] ? r_q[23:1] : r_q[22:0];
    w_normResult = {r_sign, w_normExp[7:0], w_normMant};
    if (w_normExp >= EXP_MAX) begin
      w_normResult = {r_sign, POS_INF[30:0]};
    end else if (w_normExp <= 10'sd0) begin
      w_normResult = {r_sign, 31'h0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_a       <= 32'h0;
      r_b       <= 32'h0;
      r_sign    <= 1'b0;
      r_special <= 1'b0;
      r_specRes <= 32'h0;
      r_rem     <= 25'h0;
      r_mb      <= 24'h0;
      r_q       <= 25'h0;
      r_exp     <= 10'sd0;
      r_count   <= 5'd0;
      r_result  <= 32'h0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_busy  <= 1'b1;
            r_state <= UNPACK;
          end
        end
        UNPACK: begin
          r_sign    <= w_sign;
          r_special <= w_isSpecial;
          r_specRes <= w_specRes;
          if (w_isSpecial) begin
            r_state <= NORM;
          end else begin
            r_rem   <= {2'b01, w_aMant};
            r_mb    <= {1'b1, w_bMant};
            r_exp   <= $signed({2'b00, w_aExp}) - $signed({2'b00, w_bExp}) + BIAS;
            r_count <= 5'd24;
            r_q     <= 25'h0;
            r_state <= DIVIDE;
          end
        end
        DIVIDE: begin
          r_q[r_count] <= w_ge;
          r_rem        <= w_remNext;
          if (r_count == 5'd0) begin
            r_state <= NORM;
          end else begin
            r_count <= r_count - 5'd1;
          end
        end
        NORM: begin
          r_result <= r_special ? r_specRes : w_normResult;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed testbench for fp_div_seq: reset, quotients, special cases, range limits,
// handshake behaviour and mid-operation reset.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int passCount  = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  fp_div_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Launches one operation and waits (bounded) for done; operands are scrambled after acceptance.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               output int lat, output logic [31:0] res, output bit busyOk);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 32'hDEADBEEF;
    B = 32'h12345678;
    busyOk = (busy === 1'b1);
    lat = -1;
    res = 32'hX;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = n;
        res = result;
        if (busy !== 1'b0) busyOk = 1'b0;
        break;
      end
      if (busy !== 1'b1) busyOk = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    A = 32'h0;
    B = 32'h0;
    #12;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    else passCount++;
    checkCount++;
    if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done);
    else passCount++;
    checkCount++;
    if (result !== 32'h0) $display("[TB] FAIL reset_result: got %h expected 00000000", result);
    else passCount++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Rows: dividend, divisor, expected quotient, expected latency.
  task automatic runTable(input string tag, input logic [31:0] va[], input logic [31:0] vb[],
                          input logic [31:0] vq[], input int expLat);
    int          lat;
    logic [31:0] res;
    bit          busyOk;
    for (int i = 0; i < va.size(); i++) begin
      applyStimulus(va[i], vb[i], lat, res, busyOk);
      checkCount++;
      if (res !== vq[i])
        $display("[TB] FAIL %s_result[%0d] %h/%h: got %h expected %h", tag, i, va[i], vb[i], res, vq[i]);
      else passCount++;
      checkCount++;
      if (lat != expLat)
        $display("[TB] FAIL %s_latency[%0d]: got %0d expected %0d", tag, i, lat, expLat);
      else passCount++;
      checkCount++;
      if (!busyOk) $display("[TB] FAIL %s_busy[%0d]: got 0 expected 1", tag, i);
      else passCount++;
    end
  endtask

  task automatic test_divide();
    logic [31:0] va[] = '{32'h40C00000, 32'h3F800000, 32'h41000000, 32'h3FC00000};
    logic [31:0] vb[] = '{32'h40000000, 32'h40400000, 32'hC0000000, 32'h3FC00000};
    logic [31:0] vq[] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0800000, 32'h3F800000};
    runTable("divide", va, vb, vq, 27);
  endtask

  task automatic test_special();
    logic [31:0] va[] = '{32'hBF800000, 32'h00000000, 32'h7FC00001, 32'h7F800000, 32'h80000000,
                          32'h3F800000, 32'h7F800000, 32'h00000001, 32'h3F800000};
    logic [31:0] vb[] = '{32'h00000000, 32'h00000000, 32'h3F800000, 32'hFF800000, 32'h40A00000,
                          32'h7F800000, 32'hC0000000, 32'h3F800000, 32'h00400000};
    logic [31:0] vq[] = '{32'hFF800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h80000000,
                          32'h00000000, 32'hFF800000, 32'h00000000, 32'h7F800000};
    runTable("special", va, vb, vq, 2);
  endtask

  task automatic test_range();
    logic [31:0] va[] = '{32'h7F000000, 32'h00800000, 32'hFF000000, 32'h7F000000,
                          32'h7F000000, 32'h00800000, 32'h00800000};
    logic [31:0] vb[] = '{32'h3E800000, 32'h40000000, 32'h3E800000, 32'h3F000000,
                          32'h3FC00000, 32'h3F800000, 32'h3FC00000};
    logic [31:0] vq[] = '{32'h7F800000, 32'h00000000, 32'hFF800000, 32'h7F800000,
                          32'h7EAAAAAA, 32'h00800000, 32'h00000000};
    runTable("range", va, vb, vq, 27);
  endtask

  task automatic test_busy_ignore();
    int          lat = -1;
    logic [31:0] res = 32'hX;
    @(negedge clk);
    A = 32'h40C00000;
    B = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = n;
        res = result;
        break;
      end
      if (n == 5) begin
        start = 1'b1;
        A = 32'h3F800000;
        B = 32'h40400000;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkCount++;
    if (res !== 32'h40400000) $display("[TB] FAIL ignore_result: got %h expected 40400000", res);
    else passCount++;
    checkCount++;
    if (lat != 27) $display("[TB] FAIL ignore_latency: got %0d expected 27", lat);
    else passCount++;
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL ignore_no_queue: got busy=%b expected 0", busy);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    int          lat1 = -1;
    int          lat2 = -1;
    logic [31:0] res1 = 32'hX;
    logic [31:0] res2 = 32'hX;
    logic        busy2;
    @(negedge clk);
    A = 32'h40C00000;
    B = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat1 = n;
        res1 = result;
        A = 32'h3F800000;
        B = 32'h40400000;
        start = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    busy2 = busy;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat2 = n;
        res2 = result;
        break;
      end
    end
    checkCount++;
    if (res1 !== 32'h40400000) $display("[TB] FAIL b2b_first_result: got %h expected 40400000", res1);
    else passCount++;
    checkCount++;
    if (lat1 != 27) $display("[TB] FAIL b2b_first_latency: got %0d expected 27", lat1);
    else passCount++;
    checkCount++;
    if (busy2 !== 1'b1) $display("[TB] FAIL b2b_second_accepted: got busy=%b expected 1", busy2);
    else passCount++;
    checkCount++;
    if (lat2 != 27) $display("[TB] FAIL b2b_second_latency: got %0d expected 27", lat2);
    else passCount++;
    checkCount++;
    if (res2 !== 32'h3EAAAAAA) $display("[TB] FAIL b2b_second_result: got %h expected 3EAAAAAA", res2);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    bit          sawDone = 1'b0;
    int          lat;
    logic [31:0] res;
    bit          busyOk;
    @(negedge clk);
    A = 32'h40C00000;
    B = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b expected 0", busy);
    else passCount++;
    checkCount++;
    if (result !== 32'h0) $display("[TB] FAIL midreset_result: got %h expected 00000000", result);
    else passCount++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkCount++;
    if (sawDone) $display("[TB] FAIL midreset_no_done: got done pulse expected none");
    else passCount++;
    applyStimulus(32'h41000000, 32'hC0000000, lat, res, busyOk);
    checkCount++;
    if (res !== 32'hC0800000) $display("[TB] FAIL midreset_fresh_result: got %h expected C0800000", res);
    else passCount++;
    checkCount++;
    if (lat != 27) $display("[TB] FAIL midreset_fresh_latency: got %0d expected 27", lat);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_divide();
    test_special();
    test_range();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
